// File: rtl/traffic_input_conditioner_pkg.sv
// Shared encodings for the traffic input conditioner: debounce FSM states,
// programming selector targets and the default debounce length.
package traffic_input_conditioner_pkg;

    localparam logic [1:0] STABLE_LO = 2'd0;
    localparam logic [1:0] RISE_CHK  = 2'd1;
    localparam logic [1:0] STABLE_HI = 2'd2;
    localparam logic [1:0] FALL_CHK  = 2'd3;

    localparam logic [1:0] BASE_ADD  = 2'b00;
    localparam logic [1:0] EXT_ADD   = 2'b01;
    localparam logic [1:0] YEL_ADD   = 2'b10;

    localparam int DEBOUNCE_CNT_DEF = 4;

endpackage

// File: rtl/traffic_input_conditioner_debounce_channel.sv
// One raw input: 2-flop sync, tick-qualified debounce FSM, registered edge pulses.
// Latency: raw change to level/pulse is 2 + DEBOUNCE_CNT clocks with sample_tick held high.
// Backpressure: none; pulses are single-cycle and fire-and-forget.
module debounce_channel
    import traffic_input_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CNT = DEBOUNCE_CNT_DEF,
    parameter int CNT_W        = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sample_tick,
    input  logic raw,
    output logic level,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic rise_evt
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync1_q, sync2_q;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (sample_tick) begin
            case (state_q)
                STABLE_LO: begin
                    if (sync2_q) begin
                        state_d = RISE_CHK;
                        cnt_d   = CNT_ONE;
                    end
                end
                RISE_CHK: begin
                    if (!sync2_q) begin
                        state_d = STABLE_LO;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = STABLE_HI;
                        cnt_d   = '0;
                        rise_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                STABLE_HI: begin
                    if (!sync2_q) begin
                        state_d = FALL_CHK;
                        cnt_d   = CNT_ONE;
                    end
                end
                FALL_CHK: begin
                    if (sync2_q) begin
                        state_d = STABLE_HI;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = STABLE_LO;
                        cnt_d   = '0;
                        fall_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= STABLE_LO;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // The stable level is still high while a fall is being qualified.
    assign level      = (state_q == STABLE_HI) || (state_q == FALL_CHK);
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    // Acceptance in the current cycle, so the parent can capture on the pulse edge.
    assign rise_evt   = rise_d;

endmodule

// File: rtl/traffic_input_conditioner.sv
// Conditions raw field inputs into clean levels/pulses and captures programming switches.
// Latency: 2 + DEBOUNCE_CNT clocks from raw edge to output; no backpressure, pulses are one-shot.
module traffic_input_conditioner
    import traffic_input_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CNT = DEBOUNCE_CNT_DEF,
    parameter int CNT_W        = 4
) (
    input  logic       clk,
    input  logic       Reset_n,
    input  logic       sample_tick,
    input  logic       Sensor,
    input  logic       Walk_Request,
    input  logic       Reprogram,
    input  logic [3:0] time_value,
    input  logic [1:0] selector,
    output logic       Sensor_Sync,
    output logic       WR_Sync,
    output logic       Prog_Valid,
    output logic [3:0] Prog_Sync,
    output logic [1:0] Prog_Sel
);

    logic       sns_rise_unused, sns_fall_unused, sns_evt_unused;
    logic       wr_level_unused, wr_fall_unused, wr_evt_unused;
    logic       rp_level_unused, rp_fall_unused;
    logic       rp_evt;

    logic [3:0] tv_s1_q, tv_s2_q;
    logic [1:0] sel_s1_q, sel_s2_q;
    logic [3:0] prog_sync_q, prog_sync_d;
    logic [1:0] prog_sel_q, prog_sel_d;

    debounce_channel #(.DEBOUNCE_CNT(DEBOUNCE_CNT), .CNT_W(CNT_W)) u_sensor (
        .clk        (clk),
        .rst_n      (Reset_n),
        .sample_tick(sample_tick),
        .raw        (Sensor),
        .level      (Sensor_Sync),
        .rise_pulse (sns_rise_unused),
        .fall_pulse (sns_fall_unused),
        .rise_evt   (sns_evt_unused)
    );

    debounce_channel #(.DEBOUNCE_CNT(DEBOUNCE_CNT), .CNT_W(CNT_W)) u_walk (
        .clk        (clk),
        .rst_n      (Reset_n),
        .sample_tick(sample_tick),
        .raw        (Walk_Request),
        .level      (wr_level_unused),
        .rise_pulse (WR_Sync),
        .fall_pulse (wr_fall_unused),
        .rise_evt   (wr_evt_unused)
    );

    debounce_channel #(.DEBOUNCE_CNT(DEBOUNCE_CNT), .CNT_W(CNT_W)) u_reprog (
        .clk        (clk),
        .rst_n      (Reset_n),
        .sample_tick(sample_tick),
        .raw        (Reprogram),
        .level      (rp_level_unused),
        .rise_pulse (Prog_Valid),
        .fall_pulse (rp_fall_unused),
        .rise_evt   (rp_evt)
    );

    // Value is only meaningful alongside the strobe; the target sticks for downstream muxing.
    always_comb begin
        prog_sync_d = '0;
        prog_sel_d  = prog_sel_q;
        if (rp_evt) begin
            prog_sync_d = tv_s2_q;
            prog_sel_d  = sel_s2_q;
        end
    end

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            tv_s1_q     <= '0;
            tv_s2_q     <= '0;
            sel_s1_q    <= '0;
            sel_s2_q    <= '0;
            prog_sync_q <= '0;
            prog_sel_q  <= '0;
        end else begin
            tv_s1_q     <= time_value;
            tv_s2_q     <= tv_s1_q;
            sel_s1_q    <= selector;
            sel_s2_q    <= sel_s1_q;
            prog_sync_q <= prog_sync_d;
            prog_sel_q  <= prog_sel_d;
        end
    end

    assign Prog_Sync = prog_sync_q;
    assign Prog_Sel  = prog_sel_q;

endmodule

// File: tb/tb_traffic_input_conditioner.sv
// Scoreboarded bench for traffic_input_conditioner: expected pulses are queued
// with their due cycle at stimulus time and matched by a negedge monitor.
module tb_traffic_input_conditioner;

    logic       clk = 1'b0;
    logic       Reset_n;
    logic       sample_tick = 1'b1;
    logic       Sensor, Walk_Request, Reprogram;
    logic [3:0] time_value;
    logic [1:0] selector;
    logic       Sensor_Sync, WR_Sync, Prog_Valid;
    logic [3:0] Prog_Sync;
    logic [1:0] Prog_Sel;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    bit tick_div = 1'b0;
    bit pv_prev  = 1'b0;

    typedef struct {
        int         due;
        logic [3:0] val;
        logic [1:0] sel;
    } prog_exp_t;

    int        wr_q[$];
    prog_exp_t prog_q[$];

    traffic_input_conditioner dut (
        .clk         (clk),
        .Reset_n     (Reset_n),
        .sample_tick (sample_tick),
        .Sensor      (Sensor),
        .Walk_Request(Walk_Request),
        .Reprogram   (Reprogram),
        .time_value  (time_value),
        .selector    (selector),
        .Sensor_Sync (Sensor_Sync),
        .WR_Sync     (WR_Sync),
        .Prog_Valid  (Prog_Valid),
        .Prog_Sync   (Prog_Sync),
        .Prog_Sel    (Prog_Sel)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Tick for the coming edge: every edge, or only edges whose index is a multiple of 10.
    always @(posedge clk) begin
        #1;
        sample_tick = tick_div ? ((cyc + 1) % 10 == 0) : 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic at_neg(input int n);
        wait_cyc(n);
        @(negedge clk);
    endtask

    function automatic prog_exp_t mk_prog(input int due, input logic [3:0] v, input logic [1:0] s);
        prog_exp_t e;
        e.due = due;
        e.val = v;
        e.sel = s;
        return e;
    endfunction

    always @(negedge clk) begin
        if (Reset_n) begin
            if (WR_Sync) begin
                if (wr_q.size() == 0) chk("wr_unexpected", WR_Sync, 0);
                else chk("wr_cycle", cyc, wr_q.pop_front());
            end
            if (Prog_Valid) begin
                if (prog_q.size() == 0) begin
                    chk("prog_unexpected", Prog_Valid, 0);
                end else begin
                    prog_exp_t e;
                    e = prog_q.pop_front();
                    chk("prog_cycle", cyc, e.due);
                    chk("prog_sync", Prog_Sync, e.val);
                    chk("prog_sel", Prog_Sel, e.sel);
                end
            end
            if (pv_prev && !Prog_Valid) chk("prog_sync_clr", Prog_Sync, 0);
            pv_prev = Prog_Valid;
        end else begin
            pv_prev = 1'b0;
        end
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        Reset_n      = 1'b1;
        Sensor       = 1'b1;
        Walk_Request = 1'b1;
        Reprogram    = 1'b1;
        time_value   = 4'd5;
        selector     = 2'b10;
        #2 Reset_n   = 1'b0;

        // Reset with every input high: all outputs pinned at zero.
        at_neg(2);
        chk("rst_sensor", Sensor_Sync, 0);
        chk("rst_wr", WR_Sync, 0);
        chk("rst_pv", Prog_Valid, 0);
        chk("rst_ps", Prog_Sync, 0);
        chk("rst_psel", Prog_Sel, 0);
        at_neg(4);
        chk("rst_hold", {Sensor_Sync, WR_Sync, Prog_Valid, Prog_Sync, Prog_Sel}, 0);

        wait_cyc(5);
        Reset_n = 1'b1;
        wr_q.push_back(11);
        prog_q.push_back(mk_prog(11, 4'd5, 2'b10));
        at_neg(10);
        chk("sensor_pre", Sensor_Sync, 0);
        at_neg(11);
        chk("sensor_rise", Sensor_Sync, 1);

        wait_cyc(14);
        Sensor       = 1'b0;
        Walk_Request = 1'b0;
        Reprogram    = 1'b0;
        at_neg(24);
        chk("sensor_fall", Sensor_Sync, 0);

        // Walk bounce: alternate each clock, then settle high.
        for (int i = 0; i < 8; i++) begin
            wait_cyc(30 + i);
            Walk_Request = (i % 2 == 0);
        end
        wait_cyc(38);
        Walk_Request = 1'b1;
        wr_q.push_back(44);
        wait_cyc(50);
        Walk_Request = 1'b0;

        // Tick gating: one tick every 10 clocks.
        at_neg(60);
        tick_div = 1'b1;
        wait_cyc(70);
        Sensor = 1'b1;
        at_neg(109);
        chk("gated_pre", Sensor_Sync, 0);
        at_neg(110);
        chk("gated_rise", Sensor_Sync, 1);
        wait_cyc(120);
        Sensor = 1'b0;
        wait_cyc(155);
        Sensor = 1'b1;
        at_neg(155);
        chk("dropout_mid", Sensor_Sync, 1);
        at_neg(200);
        chk("dropout_after", Sensor_Sync, 1);
        tick_div = 1'b0;

        // Reprogram capture, then switches change with no effect.
        wait_cyc(210);
        time_value = 4'd9;
        selector   = 2'b01;
        Reprogram  = 1'b1;
        prog_q.push_back(mk_prog(216, 4'd9, 2'b01));
        at_neg(217);
        chk("ps_next", Prog_Sync, 0);
        chk("psel_hold", Prog_Sel, 2'b01);
        wait_cyc(220);
        time_value = 4'd3;
        selector   = 2'b10;
        at_neg(230);
        chk("psel_keep", Prog_Sel, 2'b01);
        wait_cyc(232);
        Reprogram = 1'b0;

        // Zero value with simultaneous Walk and Reprogram presses.
        wait_cyc(250);
        time_value   = 4'd0;
        selector     = 2'b10;
        Walk_Request = 1'b1;
        Reprogram    = 1'b1;
        wr_q.push_back(256);
        prog_q.push_back(mk_prog(256, 4'd0, 2'b10));
        wait_cyc(265);
        Walk_Request = 1'b0;
        Reprogram    = 1'b0;

        // Reset during a Walk rise check; the press is abandoned.
        wait_cyc(280);
        Walk_Request = 1'b1;
        wait_cyc(284);
        Reset_n = 1'b0;
        #1;
        chk("mid_rst_sensor", Sensor_Sync, 0);
        chk("mid_rst_wr", WR_Sync, 0);
        wait_cyc(286);
        Walk_Request = 1'b0;
        wait_cyc(288);
        Reset_n = 1'b1;

        // Reset landing on the Prog_Valid cycle truncates the strobe.
        wait_cyc(300);
        time_value = 4'd7;
        selector   = 2'b01;
        Reprogram  = 1'b1;
        wait_cyc(306);
        chk("pv_pre", Prog_Valid, 1);
        chk("ps_pre", Prog_Sync, 7);
        #1;
        Reset_n = 1'b0;
        #1;
        chk("pv_trunc", Prog_Valid, 0);
        chk("ps_trunc", Prog_Sync, 0);
        chk("psel_trunc", Prog_Sel, 0);
        Reprogram = 1'b0;
        wait_cyc(309);
        Reset_n = 1'b1;
        at_neg(330);
        chk("psel_after_rst", Prog_Sel, 0);
        chk("sensor_redeb", Sensor_Sync, 1);

        chk("wr_q_empty", wr_q.size(), 0);
        chk("prog_q_empty", prog_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
